// File: rtl/sw_target_feeder.sv
// Target-sequence feeder for the Smith-Waterman systolic array: buffers a whole
// sequence, then replays it as one contiguous pe_en burst. Define SW_FEEDER_OVF_EN to add the ovf output.
module sw_target_feeder #(
    parameter int                     SCORE_WIDTH = 12,
    parameter logic [SCORE_WIDTH-1:0] ZERO        = SCORE_WIDTH'(1) << (SCORE_WIDTH - 1),
    parameter int                     MAX_LEN     = 256,
    parameter int                     LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [1:0]             s_base,
    input  logic                   s_last,
    output logic                   pe_en,
    output logic [1:0]             pe_data,
    output logic [SCORE_WIDTH-1:0] pe_M,
    output logic [SCORE_WIDTH-1:0] pe_I,
    output logic [SCORE_WIDTH-1:0] pe_High,
    input  logic                   array_vld,
    output logic                   busy,
    output logic                   done,
    output logic [LEN_W-1:0]       seq_len
`ifdef SW_FEEDER_OVF_EN
    , output logic                 ovf
`endif
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_t;

    state_t           state_q;
    logic [1:0]       mem_q [MAX_LEN];
    logic [LEN_W-1:0] wr_ptr_q;
    logic [LEN_W-1:0] rd_ptr_q;
    logic [LEN_W-1:0] seq_len_q;
    logic             s_ready_q;
    logic             pe_en_q;
    logic [1:0]       pe_data_q;
    logic             busy_q;
    logic             done_q;
`ifdef SW_FEEDER_OVF_EN
    logic             ovf_q;
`endif

    logic             accept;
    logic             room;
    logic [LEN_W-1:0] count_d;

    assign accept  = s_valid & s_ready_q;
    assign room    = wr_ptr_q < LEN_W'(MAX_LEN);
    assign count_d = room ? wr_ptr_q + LEN_W'(1) : LEN_W'(MAX_LEN);

    // Sequence storage: data only, so no reset; beats past MAX_LEN are dropped.
    always_ff @(posedge clk) begin
        if (accept && room) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= s_base;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            seq_len_q <= '0;
            s_ready_q <= 1'b0;
            pe_en_q   <= 1'b0;
            pe_data_q <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SW_FEEDER_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                // wr_ptr is 0 in IDLE, so IDLE and LOAD share the accept path.
                IDLE, LOAD: begin
                    s_ready_q <= 1'b1;
                    if (accept) begin
                        if (room) begin
                            wr_ptr_q <= wr_ptr_q + LEN_W'(1);
                        end
`ifdef SW_FEEDER_OVF_EN
                        ovf_q <= (state_q == IDLE) ? 1'b0 : (ovf_q | ~room);
`endif
                        if (s_last) begin
                            // The first base goes out on the very next cycle; a
                            // one-beat job has not reached the buffer yet.
                            seq_len_q <= count_d;
                            pe_en_q   <= 1'b1;
                            pe_data_q <= (wr_ptr_q == '0) ? s_base : mem_q[0];
                            rd_ptr_q  <= LEN_W'(1);
                            s_ready_q <= 1'b0;
                            busy_q    <= 1'b1;
                            state_q   <= STREAM;
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                end
                STREAM: begin
                    if (rd_ptr_q < seq_len_q) begin
                        pe_en_q   <= 1'b1;
                        pe_data_q <= mem_q[rd_ptr_q[IDX_W-1:0]];
                        rd_ptr_q  <= rd_ptr_q + LEN_W'(1);
                    end else begin
                        pe_en_q   <= 1'b0;
                        pe_data_q <= 2'b00;
                        state_q   <= DRAIN;
                    end
                end
                DRAIN: begin
                    // s_ready stays low this cycle, giving the next job an en-low gap.
                    if (array_vld) begin
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        wr_ptr_q <= '0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_ready = s_ready_q;
    assign pe_en   = pe_en_q;
    assign pe_data = pe_data_q;
    assign pe_M    = ZERO;
    assign pe_I    = ZERO;
    assign pe_High = ZERO;
    assign busy    = busy_q;
    assign done    = done_q;
    assign seq_len = seq_len_q;
`ifdef SW_FEEDER_OVF_EN
    assign ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_sw_target_feeder.sv
// Directed bench for sw_target_feeder with MAX_LEN=8; checks bursts, truncation,
// drain/done handshake and mid-job reset.
module tb_sw_target_feeder;

    localparam int SW = 12;
    localparam int ML = 8;
    localparam int LW = $clog2(ML + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [1:0]    s_base = 2'b00;
    logic          s_last = 1'b0;
    logic          pe_en;
    logic [1:0]    pe_data;
    logic [SW-1:0] pe_M;
    logic [SW-1:0] pe_I;
    logic [SW-1:0] pe_High;
    logic          array_vld = 1'b0;
    logic          busy;
    logic          done;
    logic [LW-1:0] seq_len;
`ifdef SW_FEEDER_OVF_EN
    logic          ovf;
`endif

    sw_target_feeder #(.SCORE_WIDTH(SW), .MAX_LEN(ML)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_base(s_base), .s_last(s_last),
        .pe_en(pe_en), .pe_data(pe_data), .pe_M(pe_M), .pe_I(pe_I), .pe_High(pe_High),
        .array_vld(array_vld), .busy(busy), .done(done), .seq_len(seq_len)
`ifdef SW_FEEDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_err = 0;
    logic [1:0] vec [16];
    logic [1:0] sent [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends vec[0..n-1]; 'gap' idle cycles between beats, optionally with array_vld high.
    task automatic send_seq(input int n, input int gap, input bit vld_gap);
        int w;
        sent.delete();
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_base  = vec[i];
            s_last  = (i == n - 1);
            w = 0;
            while (!s_ready && w < 10) begin
                tick();
                w++;
            end
            if (!s_ready) begin
                check("ready_timeout", 32'd0, 32'd1);
                s_valid = 1'b0;
                s_last  = 1'b0;
                return;
            end
            tick();
            sent.push_back(vec[i]);
            s_valid = 1'b0;
            s_last  = 1'b0;
            if (i < n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    array_vld = vld_gap;
                    tick();
                    if (vld_gap) check("no_done_in_load", done, 0);
                end
            end
            array_vld = 1'b0;
        end
    endtask

    task automatic burst(input int exp_len);
        int n;
        n = 0;
        while (pe_en && n < 20) begin
            if (n < sent.size()) check($sformatf("pe_data[%0d]", n), pe_data, sent[n]);
            check("pe_M", pe_M, 12'h800);
            check("pe_I", pe_I, 12'h800);
            check("pe_High", pe_High, 12'h800);
            n++;
            tick();
        end
        check("burst_len", n, exp_len);
        check("pe_en_after", pe_en, 0);
        check("pe_data_after", pe_data, 0);
        check("busy_drain", busy, 1);
    endtask

    task automatic finish_job(input int wait_cyc);
        for (int i = 0; i < wait_cyc; i++) begin
            tick();
            check("done_early", done, 0);
            check("ready_in_drain", s_ready, 0);
        end
        array_vld = 1'b1;
        tick();
        array_vld = 1'b0;
        check("done_pulse", done, 1);
        check("busy_at_done", busy, 0);
        check("ready_at_done", s_ready, 0);
        tick();
        check("done_once", done, 0);
        check("ready_after", s_ready, 1);
    endtask

    initial begin
        // Reset state
        rst = 1'b0;
        repeat (3) tick();
        check("rst_pe_en", pe_en, 0);
        check("rst_pe_data", pe_data, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_seq_len", seq_len, 0);
        check("rst_pe_M", pe_M, 12'h800);
        check("rst_pe_I", pe_I, 12'h800);
        check("rst_pe_High", pe_High, 12'h800);
        rst = 1'b1;
        tick();
        check("idle_ready", s_ready, 1);

        // G,A,C,T
        vec[0] = 2'b01; vec[1] = 2'b00; vec[2] = 2'b11; vec[3] = 2'b10;
        send_seq(4, 0, 0);
        check("t1_first_en", pe_en, 1);
        check("t1_first_data", pe_data, 2'b01);
        check("t1_seq_len", seq_len, 4);
        burst(4);
        finish_job(0);

        // Single beat T
        vec[0] = 2'b10;
        send_seq(1, 0, 0);
        check("t2_data", pe_data, 2'b10);
        check("t2_seq_len", seq_len, 1);
        burst(1);
        finish_job(2);

        // 10 beats into an 8-deep buffer
        for (int i = 0; i < 10; i++) vec[i] = 2'(i + 1);
        send_seq(10, 0, 0);
        check("t3_seq_len", seq_len, 8);
        burst(8);
`ifdef SW_FEEDER_OVF_EN
        check("t3_ovf", ovf, 1);
`endif
        finish_job(0);

        // s_valid every other cycle
        vec[0] = 2'b11; vec[1] = 2'b10; vec[2] = 2'b01; vec[3] = 2'b00; vec[4] = 2'b11;
        send_seq(5, 1, 0);
`ifdef SW_FEEDER_OVF_EN
        check("t4_ovf_clear", ovf, 0);
`endif
        check("t4_seq_len", seq_len, 5);
        burst(5);
        finish_job(1);

        // Reset at base 3 of 6
        vec[0] = 2'b00; vec[1] = 2'b01; vec[2] = 2'b10; vec[3] = 2'b11; vec[4] = 2'b00; vec[5] = 2'b01;
        send_seq(6, 0, 0);
        check("t5_en", pe_en, 1);
        tick();
        tick();
        check("t5_base3", pe_data, 2'b10);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("t5_rst_en", pe_en, 0);
        check("t5_rst_data", pe_data, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_seq_len", seq_len, 0);
        tick();
        check("t5_idle_ready", s_ready, 1);
        vec[0] = 2'b11; vec[1] = 2'b01;
        send_seq(2, 0, 0);
        check("t5_seq_len", seq_len, 2);
        burst(2);
        finish_job(0);

        // array_vld during LOAD is ignored
        vec[0] = 2'b10; vec[1] = 2'b11; vec[2] = 2'b00;
        send_seq(3, 2, 1);
        check("t6_seq_len", seq_len, 3);
        burst(3);
        finish_job(0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sw_target_feeder.md
Name: sw_target_feeder

Overview:
- Upstream feeder for the Smith-Waterman systolic array; drives the first processing element.
- Accepts a target sequence as 2-bit bases over a valid/ready stream and buffers the whole sequence.
- Replays the buffered sequence with a contiguous enable burst, one base per cycle, with biased-zero score inputs.
- Holds off the next sequence until the last PE reports vld, so every job is separated by at least one en-low cycle.

Parameters:
- SCORE_WIDTH, 12: score bus width; must match the array.
- ZERO, 2**(SCORE_WIDTH-1): biased zero driven on the score inputs.
- MAX_LEN, 256: buffer depth in bases; must be >= 1.
- LEN_W, $clog2(MAX_LEN+1): width of the length and index counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- s_valid  in  1  input base valid.
- s_ready  out  1  feeder accepts a base this cycle.
- s_base  in  2  target base (A=00, G=01, T=10, C=11).
- s_last  in  1  marks the final base of the sequence.
- pe_en  out  1  en_in of the first PE.
- pe_data  out  2  data_in of the first PE.
- pe_M  out  SCORE_WIDTH  M_in of the first PE.
- pe_I  out  SCORE_WIDTH  I_in of the first PE.
- pe_High  out  SCORE_WIDTH  High_in of the first PE.
- array_vld  in  1  vld from the last PE.
- busy  out  1  high in STREAM or DRAIN.
- done  out  1  one-cycle pulse when a job completes.
- seq_len  out  LEN_W  number of bases streamed in the current or last job.
- ovf  out  1  present only with SW_FEEDER_OVF_EN; see Optional Feature.

Behaviour:
- Reset (rst==0 at posedge clk), all values registered:
  - state=IDLE; pe_en=0, pe_data=00, s_ready=0, busy=0, done=0, seq_len=0, wr_ptr=0, rd_ptr=0.
  - pe_M, pe_I and pe_High are constant ZERO at all times, including during reset.
- Reset mid-job aborts immediately; the buffer contents are don't-care afterwards.
- States: IDLE, LOAD, STREAM, DRAIN.
- IDLE:
  - s_ready=1; wr_ptr=0.
  - The first accepted beat (s_valid & s_ready) writes buf[0] and sets wr_ptr=1.
  - Go to LOAD, or, if s_last is set on that beat, go directly to STREAM with length 1.
- LOAD:
  - s_ready=1. Each accepted beat writes buf[wr_ptr] and increments wr_ptr.
  - When wr_ptr==MAX_LEN, beats are still accepted but discarded; wr_ptr saturates at MAX_LEN.
  - On an accepted beat with s_last: seq_len = final count (min(count, MAX_LEN)), rd_ptr=0, go to STREAM.
- STREAM:
  - s_ready=0.
  - Each cycle: pe_en=1, pe_data=buf[rd_ptr], rd_ptr++.
  - First pe_en=1 appears on the cycle after s_last is accepted.
  - pe_en stays high for exactly seq_len consecutive cycles with no bubbles.
  - After the last base, pe_en=0 and pe_data=00; go to DRAIN.
- DRAIN:
  - s_ready=0, pe_en=0.
  - Wait for array_vld==1, then pulse done=1 for one cycle and go to IDLE.
  - array_vld seen in any other state is ignored.
- busy is high in STREAM and DRAIN.
- Back-to-back jobs: s_ready reasserts in the cycle after done. This guarantees at least one en-low cycle between bursts.
- s_valid held with s_ready=0 does not consume the beat; the source must hold the beat stable until it is accepted.

Optional Feature:
- Macro: SW_FEEDER_OVF_EN.
- When defined:
  - Output ovf exists. It is set to 1 on any accepted beat while wr_ptr==MAX_LEN.
  - ovf stays set through STREAM and DRAIN and clears on the first accepted beat of the next job or on reset.
- When undefined:
  - No ovf port; excess beats are discarded silently.
  - Truncation behaviour is otherwise identical.

Test Plan:
- Reset, then send 4 beats G,A,C,T with s_last on T -> pe_en high for exactly 4 cycles starting the cycle after the T beat; pe_data=01,00,11,10; seq_len=4; pe_M=pe_I=pe_High=0x800 throughout.
- Single beat T with s_last in IDLE -> 1-cycle pe_en burst with pe_data=10, then DRAIN; assert array_vld 3 cycles later -> done pulses once, s_ready=1 on the next cycle.
- MAX_LEN=8, send 10 beats with s_last on beat 10 -> seq_len=8; 8 pe_en cycles carrying beats 1-8; ovf=1 when the macro is defined.
- Toggle s_valid every other cycle during LOAD with 5 beats -> buffer holds 5 bases in order; STREAM burst is contiguous with no gaps.
- Pulse rst low during STREAM at base 3 of 6 -> next cycle pe_en=0, pe_data=00, busy=0, state IDLE; a new 2-base job then completes normally.
- Assert array_vld during LOAD -> ignored; no done pulse, and the job proceeds normally.
